// File: rtl/rtmq_dp_mem_pipe.sv
// rtmq_dp_mem_pipe: dual-port RTMQ main memory with stallable fetch port A and byte-write data port B
module rtmq_dp_mem_pipe #(
  parameter int    W_DAT     = 32,
  parameter int    W_ADR     = 12,
  parameter int    LAT_A     = 3,
  parameter int    LAT_B     = 3,
  parameter int    RDW_B     = 0,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_ADR-1:0]   adr_a,
  input  logic               en_a,
  output logic [W_DAT-1:0]   dat_a,
  output logic               vld_a,
  input  logic [W_ADR-1:0]   adr_b,
  input  logic               re_b,
  input  logic               we_b,
  input  logic [W_DAT/8-1:0] be_b,
  input  logic [W_DAT-1:0]   din_b,
  output logic [W_DAT-1:0]   dat_b,
  output logic               vld_b
);
  localparam int NB = W_DAT / 8;
  logic [W_DAT-1:0] mem [2**W_ADR];
  logic [W_DAT-1:0] old_b, new_b;
  logic [W_DAT-1:0] pa [LAT_A];
  logic             va [LAT_A];
  logic [W_DAT-1:0] pb [LAT_B];
  logic             vb [LAT_B];
  if (LAT_A < 1 || LAT_A > 4 || LAT_B < 1 || LAT_B > 4 || W_DAT % 8 != 0) begin : g_bad
    $fatal(1, "rtmq_dp_mem_pipe: illegal LAT_A/LAT_B/W_DAT");
  end
  always_comb begin
    old_b = mem[adr_b];
    new_b = old_b;
    for (int i = 0; i < NB; i++)
      if (be_b[i]) new_b[8*i +: 8] = din_b[8*i +: 8];
  end
  always_ff @(posedge clk)
    if (!rst && we_b) mem[adr_b] <= new_b;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LAT_A; i++) pa[i] <= '0;
      for (int i = 0; i < LAT_A; i++) va[i] <= 1'b0;
    end else if (en_a) begin
      pa[0] <= mem[adr_a];
      va[0] <= 1'b1;
      for (int i = 1; i < LAT_A; i++) pa[i] <= pa[i-1];
      for (int i = 1; i < LAT_A; i++) va[i] <= va[i-1];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LAT_B; i++) pb[i] <= '0;
      for (int i = 0; i < LAT_B; i++) vb[i] <= 1'b0;
    end else begin
      vb[0] <= re_b;
      if (re_b) pb[0] <= (RDW_B != 0 && we_b) ? new_b : old_b;
      for (int i = 1; i < LAT_B; i++) pb[i] <= pb[i-1];
      for (int i = 1; i < LAT_B; i++) vb[i] <= vb[i-1];
    end
  assign dat_a = pa[LAT_A-1];
  assign vld_a = va[LAT_A-1];
  assign dat_b = pb[LAT_B-1];
  assign vld_b = vb[LAT_B-1];
endmodule

// File: tb/tb_rtmq_dp_mem_pipe.sv
// tb_rtmq_dp_mem_pipe: directed bench driving three latency/RDW variants from one stimulus
module tb_rtmq_dp_mem_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adr_a = '0, adr_b = '0;
  logic        en_a = 1'b0, re_b = 1'b0, we_b = 1'b0;
  logic [3:0]  be_b = '0;
  logic [31:0] din_b = '0;
  logic [31:0] dat_a [3];
  logic [31:0] dat_b [3];
  logic        vld_a [3];
  logic        vld_b [3];
  int          la [3] = '{3, 1, 4};
  int          n_chk = 0, n_err = 0;
  int          ne;
  always #5 clk = ~clk;
  rtmq_dp_mem_pipe #(.LAT_A(3), .LAT_B(3), .RDW_B(0)) u0 (
    .clk(clk), .rst(rst), .adr_a(adr_a), .en_a(en_a), .dat_a(dat_a[0]), .vld_a(vld_a[0]),
    .adr_b(adr_b), .re_b(re_b), .we_b(we_b), .be_b(be_b), .din_b(din_b), .dat_b(dat_b[0]), .vld_b(vld_b[0]));
  rtmq_dp_mem_pipe #(.LAT_A(1), .LAT_B(1), .RDW_B(1)) u1 (
    .clk(clk), .rst(rst), .adr_a(adr_a), .en_a(en_a), .dat_a(dat_a[1]), .vld_a(vld_a[1]),
    .adr_b(adr_b), .re_b(re_b), .we_b(we_b), .be_b(be_b), .din_b(din_b), .dat_b(dat_b[1]), .vld_b(vld_b[1]));
  rtmq_dp_mem_pipe #(.LAT_A(4), .LAT_B(4), .RDW_B(0)) u2 (
    .clk(clk), .rst(rst), .adr_a(adr_a), .en_a(en_a), .dat_a(dat_a[2]), .vld_a(vld_a[2]),
    .adr_b(adr_b), .re_b(re_b), .we_b(we_b), .be_b(be_b), .din_b(din_b), .dat_b(dat_b[2]), .vld_b(vld_b[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s dat_a u%0d", tag, k), dat_a[k], 32'h0);
      check($sformatf("%s vld_a u%0d", tag, k), {31'b0, vld_a[k]}, 32'h0);
      check($sformatf("%s dat_b u%0d", tag, k), dat_b[k], 32'h0);
      check($sformatf("%s vld_b u%0d", tag, k), {31'b0, vld_b[k]}, 32'h0);
    end
  endtask
  task automatic wr_b(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
    adr_b = a; din_b = d; be_b = b; we_b = 1'b1;
    step();
    we_b = 1'b0;
  endtask
  // issues one B read (plus any write the caller set up) and follows it through all three latencies
  task automatic rd_b(input logic [11:0] a, input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
    logic [31:0] x [3];
    x[0] = x0; x[1] = x1; x[2] = x2;
    adr_b = a; re_b = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      re_b = 1'b0; we_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("vld_b u%0d a%h s%0d", k, a, s), {31'b0, vld_b[k]}, {31'b0, s == la[k] - 1});
        if (s >= la[k] - 1) check($sformatf("dat_b u%0d a%h s%0d", k, a, s), dat_b[k], x[k]);
      end
    end
  endtask
  initial begin
    step();
    chk_zero("reset");
    rst = 1'b0;
    for (int n = 0; n < 16; n++) wr_b(12'(n), 32'(n), 4'hF);
    // fetch stream with a two-cycle stall after address 5 is issued
    ne = 0;
    for (int it = 0; it < 12; it++) begin
      en_a = !(it == 6 || it == 7);
      adr_a = en_a ? 12'(ne) : 12'hFFF;
      step();
      if (en_a) ne++;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("vld_a u%0d it%0d", k, it), {31'b0, vld_a[k]}, {31'b0, ne >= la[k]});
        if (ne >= la[k]) check($sformatf("dat_a u%0d it%0d", k, it), dat_a[k], 32'(ne - la[k]));
      end
    end
    en_a = 1'b0;
    // byte-enable writes, including an all-zero enable
    wr_b(12'h010, 32'hAABBCCDD, 4'b1111);
    wr_b(12'h010, 32'h11223344, 4'b0101);
    rd_b(12'h010, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    wr_b(12'h010, 32'h00000000, 4'b0000);
    rd_b(12'h010, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    // read-during-write: u1 is write-first, u0/u2 read-first
    wr_b(12'h020, 32'h00000000, 4'hF);
    wr_b(12'h021, 32'h12345678, 4'hF);
    we_b = 1'b1; din_b = 32'hFFFF0000; be_b = 4'b1100;
    rd_b(12'h020, 32'h00000000, 32'hFFFF0000, 32'h00000000);
    rd_b(12'h020, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000);
    we_b = 1'b1; din_b = 32'hFFFF0000; be_b = 4'b1100;
    rd_b(12'h021, 32'h12345678, 32'hFFFF5678, 32'h12345678);
    rd_b(12'h021, 32'hFFFF5678, 32'hFFFF5678, 32'hFFFF5678);
    // cross-port collision: A sees old word on the write edge, new word one edge later
    wr_b(12'h030, 32'h12345678, 4'hF);
    en_a = 1'b1; adr_a = 12'h030;
    adr_b = 12'h030; din_b = 32'hDEADBEEF; be_b = 4'hF; we_b = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      we_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (s == la[k] - 1) check($sformatf("coll old u%0d", k), dat_a[k], 32'h12345678);
        if (s == la[k]) check($sformatf("coll new u%0d", k), dat_a[k], 32'hDEADBEEF);
      end
    end
    en_a = 1'b0;
    // asynchronous reset with reads in flight, then a write attempted under reset
    re_b = 1'b1;
    adr_b = 12'h010; step();
    adr_b = 12'h020; step();
    adr_b = 12'h030; step();
    re_b = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    adr_b = 12'h010; din_b = 32'h0; be_b = 4'hF; we_b = 1'b1;
    step();
    step();
    chk_zero("rst_hold");
    we_b = 1'b0;
    rst = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      for (int k = 0; k < 3; k++) check($sformatf("post_rst vld_b u%0d s%0d", k, s), {31'b0, vld_b[k]}, 32'h0);
    end
    rd_b(12'h010, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    rd_b(12'h030, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
